// File: rtl/hazard_unit_pkg.sv
// hazard_pkg: shared types and helpers for the pipeline hazard controller.
//   hz_state_t : FSM states of hazard_unit (idle, draining RET bubbles, halted)
//   ZERO_REG   : architectural zero register, which never creates a hazard
//   max_int    : constant helper used to size the bubble counters
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_IDLE,
    HZ_RET_DRAIN,
    HZ_HALTED
  } hz_state_t;

  localparam logic [31:0] ZERO_REG = '0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_unit_bubble_counter.sv
// bubble_counter: loadable down-counter that defines a bubble window.
//   clk, rst : clock and asynchronous active-high reset
//   load     : load DEPTH into the counter
//   clr      : clear the counter (wins over load)
//   busy     : counter is non-zero (window active)
//   cnt      : remaining cycles of the window
// The counter saturates at zero and never wraps.
module bubble_counter #(
  parameter int DEPTH = 1,
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clr,
  output logic             busy,
  output logic [CNT_W-1:0] cnt
);

  // A fresh load restarts the window rather than adding to it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(DEPTH);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller beside the ID stage of the 5-stage CPU.
// Detects load-use hazards, opens stall windows after RET, flush windows after
// taken branches, and holds the core in a sticky HALT state until reset.
//
// Ports:
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   id_src_addr    : packed ID source register addresses, src0 in the LSBs
//   id_src_used    : per-source valid; unused sources never hazard
//   ex_dst_addr    : destination register of the instruction in EX
//   ex_mem_read    : instruction in EX is a load
//   cur_ret        : RET decoded in ID
//   br_taken       : branch resolved taken in EX
//   halt           : HLT decoded in ID
//   stall          : hold PC and IF/ID, bubble into ID/EX
//   flush_id       : zero the IF/ID register
//   load_use       : combinational load-use hazard
//   bubble_cnt     : remaining RET bubble cycles
//   halted         : core halted
//   perf_stall_cnt : stall cycles outside HALT (live only with HAZARD_PERF_EN)
//
// Build option: define HAZARD_PERF_EN to enable the stall performance counter;
// otherwise perf_stall_cnt is tied to zero.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 4,
  parameter int NUM_SRC     = 2,
  parameter int RET_BUBBLES = 3,
  parameter int BR_BUBBLES  = 1,
  parameter int CNT_W       = $clog2(max_int(RET_BUBBLES, BR_BUBBLES) + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         ex_dst_addr,
  input  logic                          ex_mem_read,
  input  logic                          cur_ret,
  input  logic                          br_taken,
  input  logic                          halt,
  output logic                          stall,
  output logic                          flush_id,
  output logic                          load_use,
  output logic [CNT_W-1:0]              bubble_cnt,
  output logic                          halted,
  output logic [31:0]                   perf_stall_cnt
);

  hz_state_t        state;
  logic             src_hit;
  logic             load_use_raw;
  logic             is_halted;
  logic             halt_take;
  logic             ret_load;
  logic             ret_clr;
  logic             br_load;
  logic             ret_busy;
  logic             br_busy;
  logic [CNT_W-1:0] ret_cnt;
  logic [CNT_W-1:0] br_cnt_unused;

  // Compare every used source operand against the load destination in EX.
  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i] &&
          (id_src_addr[i*REG_ADDR_W +: REG_ADDR_W] == ex_dst_addr)) begin
        src_hit = 1'b1;
      end
    end
  end

  assign load_use_raw = ex_mem_read && src_hit &&
                        (ex_dst_addr != REG_ADDR_W'(ZERO_REG));

  assign is_halted = (state == HZ_HALTED);

  // Halt is only accepted on a cycle without stall; otherwise ID re-presents it.
  assign halt_take = halt && !stall && !is_halted;

  // A taken branch squashes a same-cycle RET (it is on the wrong path).
  assign ret_clr  = br_taken && !is_halted;
  assign ret_load = cur_ret && !br_taken && !is_halted && !halt_take;
  assign br_load  = br_taken && !is_halted;

  bubble_counter #(
    .DEPTH (RET_BUBBLES),
    .CNT_W (CNT_W)
  ) u_ret_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (ret_load),
    .clr  (ret_clr),
    .busy (ret_busy),
    .cnt  (ret_cnt)
  );

  // The branch window counts the cycles after the combinational first flush.
  bubble_counter #(
    .DEPTH (BR_BUBBLES - 1),
    .CNT_W (CNT_W)
  ) u_br_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (br_load),
    .clr  (1'b0),
    .busy (br_busy),
    .cnt  (br_cnt_unused)
  );

  // Control FSM; RET_DRAIN tracks the RET counter and HALTED is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HZ_IDLE;
    end else begin
      case (state)
        HZ_IDLE: begin
          if (halt_take) begin
            state <= HZ_HALTED;
          end else if (ret_load) begin
            state <= HZ_RET_DRAIN;
          end
        end
        HZ_RET_DRAIN: begin
          if (halt_take) begin
            state <= HZ_HALTED;
          end else if (br_taken) begin
            state <= HZ_IDLE;
          end else if (!cur_ret && (ret_cnt == CNT_W'(1))) begin
            state <= HZ_IDLE;
          end
        end
        HZ_HALTED: begin
          state <= HZ_HALTED;
        end
        default: begin
          state <= HZ_IDLE;
        end
      endcase
    end
  end

  // Outputs are gated by rst so they drop asynchronously with reset.
  assign load_use   = !rst && load_use_raw;
  assign stall      = !rst && (load_use_raw || ret_busy || is_halted);
  assign flush_id   = !rst && ((br_taken && !is_halted) || br_busy);
  assign bubble_cnt = ret_cnt;
  assign halted     = is_halted;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_q;

  // Counts stall cycles caused by hazards, not by HALT; saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if (stall && !is_halted && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: self-checking bench for hazard_unit.
// Each step drives one cycle of inputs shortly after a rising edge, a reference
// model pushes the expected outputs into a scoreboard queue, and a checker pops
// and compares them on the following falling edge.
module tb_hazard_unit;

  localparam int REG_ADDR_W  = 4;
  localparam int NUM_SRC     = 2;
  localparam int RET_BUBBLES = 3;
  localparam int BR_BUBBLES  = 1;
  localparam int CNT_W       = 2;

  typedef struct {
    logic        lu;
    logic        st;
    logic        fl;
    logic        hl;
    logic [31:0] bub;
    logic [31:0] perf;
  } exp_t;

  logic                          clk;
  logic                          rst;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr;
  logic [NUM_SRC-1:0]            id_src_used;
  logic [REG_ADDR_W-1:0]         ex_dst_addr;
  logic                          ex_mem_read;
  logic                          cur_ret;
  logic                          br_taken;
  logic                          halt;
  logic                          stall;
  logic                          flush_id;
  logic                          load_use;
  logic [CNT_W-1:0]              bubble_cnt;
  logic                          halted;
  logic [31:0]                   perf_stall_cnt;

  exp_t sbq[$];
  exp_t cur_exp;
  int   total = 0;
  int   bad   = 0;

  int   m_ret = 0, m_br = 0, m_perf = 0;
  logic m_halt = 1'b0;
  int   n_ret = 0, n_br = 0, n_perf = 0;
  logic n_halt = 1'b0;

  hazard_unit #(
    .REG_ADDR_W  (REG_ADDR_W),
    .NUM_SRC     (NUM_SRC),
    .RET_BUBBLES (RET_BUBBLES),
    .BR_BUBBLES  (BR_BUBBLES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_src_addr    (id_src_addr),
    .id_src_used    (id_src_used),
    .ex_dst_addr    (ex_dst_addr),
    .ex_mem_read    (ex_mem_read),
    .cur_ret        (cur_ret),
    .br_taken       (br_taken),
    .halt           (halt),
    .stall          (stall),
    .flush_id       (flush_id),
    .load_use       (load_use),
    .bubble_cnt     (bubble_cnt),
    .halted         (halted),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Drive one cycle of inputs and push the model's expected outputs.
  task automatic applyStimulus(input logic r, input logic [7:0] src,
                               input logic [1:0] used, input logic [3:0] dst,
                               input logic mr, input logic ret,
                               input logic br, input logic hlt);
    logic lu, st, take;
    exp_t e;
    @(posedge clk);
    m_ret = n_ret; m_br = n_br; m_halt = n_halt; m_perf = n_perf;
    #1;
    rst = r; id_src_addr = src; id_src_used = used; ex_dst_addr = dst;
    ex_mem_read = mr; cur_ret = ret; br_taken = br; halt = hlt;

    lu = mr && (dst != 4'd0) &&
         ((used[0] && (src[3:0] == dst)) || (used[1] && (src[7:4] == dst)));
    st = lu || (m_ret != 0) || m_halt;

    e.lu   = r ? 1'b0 : lu;
    e.st   = r ? 1'b0 : st;
    e.fl   = r ? 1'b0 : ((br && !m_halt) || (m_br != 0));
    e.hl   = r ? 1'b0 : m_halt;
    e.bub  = r ? 32'd0 : 32'(m_ret);
`ifdef HAZARD_PERF_EN
    e.perf = r ? 32'd0 : 32'(m_perf);
`else
    e.perf = 32'd0;
`endif
    sbq.push_back(e);

    if (r) begin
      n_ret = 0; n_br = 0; n_halt = 1'b0; n_perf = 0;
    end else begin
      n_perf = (st && !m_halt) ? m_perf + 1 : m_perf;
      n_br   = (m_br > 0) ? m_br - 1 : 0;
      n_ret  = (m_ret > 0) ? m_ret - 1 : 0;
      n_halt = m_halt;
      if (!m_halt) begin
        take = hlt && !st;
        if (br) begin
          n_br  = BR_BUBBLES - 1;
          n_ret = 0;
        end else if (ret && !take) begin
          n_ret = RET_BUBBLES;
        end
        if (take) n_halt = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 2'b00, 4'd0, 0, 0, 0, 0);
  endtask

  // Scoreboard consumer: compares the DUT against the oldest expectation.
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      cur_exp = sbq.pop_front();
      checkOutput("load_use",   32'(load_use),   32'(cur_exp.lu));
      checkOutput("stall",      32'(stall),      32'(cur_exp.st));
      checkOutput("flush_id",   32'(flush_id),   32'(cur_exp.fl));
      checkOutput("halted",     32'(halted),     32'(cur_exp.hl));
      checkOutput("bubble_cnt", 32'(bubble_cnt), cur_exp.bub);
      checkOutput("perf",       perf_stall_cnt,  cur_exp.perf);
    end
  end

  initial begin
    rst = 1'b1; id_src_addr = '0; id_src_used = '0; ex_dst_addr = '0;
    ex_mem_read = 1'b0; cur_ret = 1'b0; br_taken = 1'b0; halt = 1'b0;

    $display("[TB] reset");
    applyStimulus(1, 8'h00, 2'b00, 4'd0, 0, 0, 0, 0);
    applyStimulus(1, 8'h00, 2'b00, 4'd0, 0, 0, 0, 0);
    idle(1);

    $display("[TB] load-use");
    applyStimulus(0, 8'h53, 2'b11, 4'd5, 1, 0, 0, 0);
    applyStimulus(0, 8'h00, 2'b11, 4'd0, 1, 0, 0, 0);
    applyStimulus(0, 8'h53, 2'b01, 4'd5, 1, 0, 0, 0);
    applyStimulus(0, 8'h53, 2'b10, 4'd5, 1, 0, 0, 0);
    applyStimulus(0, 8'h53, 2'b11, 4'd5, 0, 0, 0, 0);
    applyStimulus(0, 8'h35, 2'b01, 4'd5, 1, 0, 0, 0);

    $display("[TB] ret window");
    applyStimulus(0, 8'h00, 2'b00, 4'd0, 0, 1, 0, 0);
    idle(4);

    $display("[TB] ret reload");
    applyStimulus(0, 8'h00, 2'b00, 4'd0, 0, 1, 0, 0);
    idle(1);
    applyStimulus(0, 8'h00, 2'b00, 4'd0, 0, 1, 0, 0);
    idle(4);

    $display("[TB] branch vs ret");
    applyStimulus(0, 8'h00, 2'b00, 4'd0, 0, 1, 1, 0);
    idle(2);
    applyStimulus(0, 8'h00, 2'b00, 4'd0, 0, 1, 0, 0);
    applyStimulus(0, 8'h00, 2'b00, 4'd0, 0, 0, 1, 0);
    applyStimulus(0, 8'h66, 2'b11, 4'd6, 1, 0, 1, 0);
    idle(2);

    $display("[TB] halt");
    applyStimulus(0, 8'h00, 2'b00, 4'd0, 0, 1, 0, 0);
    applyStimulus(0, 8'h00, 2'b00, 4'd0, 0, 0, 0, 1);
    idle(3);
    applyStimulus(0, 8'h00, 2'b00, 4'd0, 0, 0, 0, 1);
    applyStimulus(0, 8'h00, 2'b00, 4'd0, 0, 1, 0, 0);
    applyStimulus(0, 8'h00, 2'b00, 4'd0, 0, 0, 1, 0);
    idle(2);
    applyStimulus(1, 8'h00, 2'b00, 4'd0, 0, 0, 0, 0);
    idle(2);

    $display("[TB] reset mid-drain");
    applyStimulus(0, 8'h00, 2'b00, 4'd0, 0, 1, 0, 0);
    idle(1);
    applyStimulus(1, 8'h00, 2'b00, 4'd0, 0, 0, 0, 0);
    idle(4);

    $display("[TB] random");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(($urandom_range(0, 14) == 0),
                    {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
                    2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0));
    end
    idle(2);

    @(negedge clk);
    #1;
    checkOutput("sb_drain", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Parametrised pipeline hazard controller for the 5-stage CPU. It sits beside the ID stage and generalises the fixed 3-cycle return stall with an external data-dependency input. It detects load-use hazards internally from register addresses and generates configurable-depth bubble windows for RET and taken branches. It also provides sticky HALT handling and drives one stall and one flush output to the IF/ID pipeline registers.

Parameters:
REG_ADDR_W, 4, register-file address width
NUM_SRC, 2, number of ID-stage source operands checked
RET_BUBBLES, 3, stall cycles after a RET (>=1)
BR_BUBBLES, 1, IF/ID flush cycles after a taken branch (>=1)
CNT_W, $clog2(max(RET_BUBBLES,BR_BUBBLES)+1), bubble counter width (derived; do not override)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
id_src_addr  in  NUM_SRC*REG_ADDR_W  packed ID source register addresses, src0 in LSBs
id_src_used  in  NUM_SRC  per-source valid; an unused source never causes a hazard
ex_dst_addr  in  REG_ADDR_W  destination register of the instruction in EX
ex_mem_read  in  1  the instruction in EX is a load
cur_ret  in  1  RET decoded in ID this cycle
br_taken  in  1  branch resolved taken in EX this cycle
halt  in  1  HLT decoded in ID
stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
flush_id  out  1  zero the IF/ID register
load_use  out  1  combinational load-use hazard indication
bubble_cnt  out  CNT_W  remaining RET bubble cycles (debug)
halted  out  1  core halted

Behaviour:
- Reset (async): state=IDLE, ret_cnt=0, br_cnt=0, halted=0. While rst=1, stall, flush_id and load_use are forced to 0.
- load_use (combinational) = ex_mem_read AND OR over i of (id_src_used[i] AND id_src_addr[i]==ex_dst_addr AND ex_dst_addr!=0). Register 0 never hazards.
- FSM states: IDLE, RET_DRAIN, HALTED.
- IDLE -> RET_DRAIN on cur_ret: ret_cnt<=RET_BUBBLES at that edge.
- RET_DRAIN decrements ret_cnt each cycle and returns to IDLE on the edge where ret_cnt goes 1->0.
- cur_ret while in RET_DRAIN reloads ret_cnt to RET_BUBBLES. There is no accumulation.
- Any state -> HALTED on halt, unless stall is high that cycle. In that case halt is ignored and ID re-presents it.
- HALTED is sticky until rst. cur_ret and br_taken are ignored in HALTED.
- stall = load_use OR (ret_cnt!=0) OR halted. stall is never registered from load_use.
- Latency: cur_ret sampled at edge N gives stall high on cycles N+1..N+RET_BUBBLES.
- br_taken: flush_id is asserted combinationally in the same cycle. br_cnt<=BR_BUBBLES-1, and flush_id stays high while br_cnt!=0. flush_id = br_taken OR (br_cnt!=0).
- Simultaneous br_taken and cur_ret: the branch wins. The RET is on the wrong path, so cur_ret is ignored and ret_cnt is cleared to 0.
- Simultaneous load_use and flush_id: both are asserted. The flush has priority at IF/ID; ID/EX still receives a bubble.
- bubble_cnt = ret_cnt. Counters saturate at 0 and never wrap.
- Reset mid-drain: the counter clears immediately and stall drops asynchronously with rst.

Optional Feature:
HAZARD_PERF_EN:
- Defined: adds output perf_stall_cnt[31:0]. It increments on every cycle with stall=1 and halted=0, saturates at 32'hFFFF_FFFF, and resets to 0.
- Undefined: the port still exists and is tied to 32'h0, and no counter logic is inferred.

Decomposition:
- Package hazard_pkg holds:
  - typedef enum logic [1:0] {HZ_IDLE, HZ_RET_DRAIN, HZ_HALTED} hz_state_t
  - localparam ZERO_REG = '0
  - function max_int for sizing CNT_W
- One sub-module, bubble_counter (parameter DEPTH, CNT_W):
  - inputs load and clr; outputs busy and cnt
  - instantiated twice, for RET and branch windows

Test Plan:
- Load-use: ex_mem_read=1, ex_dst_addr=5, id_src_addr={5,3}, used=2'b11 -> load_use=1, stall=1 same cycle. With ex_dst_addr=0 -> both 0.
- RET, RET_BUBBLES=3: cur_ret pulse at edge 10 -> stall=1 on cycles 11,12,13; bubble_cnt 3,2,1; stall=0 at cycle 14.
- RET reload: second cur_ret at cycle 12 -> stall continues through cycle 15; bubble_cnt reloads to 3.
- Branch vs RET: br_taken=1 and cur_ret=1 in the same cycle -> flush_id=1 for BR_BUBBLES cycles; stall stays 0; bubble_cnt=0.
- HALT: halt=1 with no stall -> halted=1 and stall=1 permanently. Later cur_ret or br_taken have no effect. Asserting rst mid-cycle -> halted=0 and stall=0 immediately.
- Reset mid-drain: rst during bubble_cnt=2 -> stall=0 asynchronously; after release, stall=0 with no residual bubbles. With HAZARD_PERF_EN, perf_stall_cnt=0.
